// File: rtl/instr_fetch.sv
// RV32 fetch stage: owns the PC, issues in-order imem reads and
// hands {pc, instr} pairs to decode through a 2-entry buffer.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  logic [31:0] pc;
  logic [31:0] e_pc    [2];
  logic [31:0] e_instr [2];
  logic [1:0]  e_filled;
  logic        head;
  logic        tail;
  logic [1:0]  alloc_cnt;
  logic [1:0]  drop_cnt;

  logic        pop;
  logic        accept;
  logic        fill_idx;
  logic [1:0]  filled_cnt;
  logic [1:0]  unfilled_cnt;
  logic [2:0]  credit;

  assign if_valid = e_filled[head];
  assign if_pc    = e_pc[head];
  assign if_instr = e_instr[head];

  assign pop = if_valid & if_ready;

  // Slots in use after this cycle's pop, counting
  // reads still owed for flushed requests.
  assign credit = {1'b0, alloc_cnt}
                - {2'b00, pop}
                + {1'b0, drop_cnt};

  assign imem_req_valid = !rst
                        & !redirect_valid
                        & (credit < 3'd2);
  assign imem_req_addr  = pc;
  assign accept = imem_req_valid & imem_req_ready;

  // Filled entries always form a prefix starting at head,
  // so the oldest unfilled one is head or the one after.
  assign fill_idx = e_filled[head] ? ~head : head;

  assign filled_cnt   = {1'b0, e_filled[0]}
                      + {1'b0, e_filled[1]};
  assign unfilled_cnt = alloc_cnt - filled_cnt;

  // PC, buffer and counter update; redirect overrides everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      e_pc[0]    <= '0;
      e_pc[1]    <= '0;
      e_instr[0] <= '0;
      e_instr[1] <= '0;
      e_filled   <= '0;
      head       <= 1'b0;
      tail       <= 1'b0;
      alloc_cnt  <= '0;
      drop_cnt   <= '0;
    end else if (redirect_valid) begin
      pc        <= redirect_pc;
      e_filled  <= '0;
      head      <= 1'b0;
      tail      <= 1'b0;
      alloc_cnt <= '0;
      drop_cnt  <= drop_cnt
                 + unfilled_cnt
                 - {1'b0, imem_rsp_valid};
    end else begin
      if (pop) begin
        e_filled[head] <= 1'b0;
        head           <= ~head;
      end
      if (accept) begin
        e_pc[tail]     <= pc;
        e_filled[tail] <= 1'b0;
        tail           <= ~tail;
        pc             <= pc + 32'd4;
      end
      if (imem_rsp_valid) begin
        if (drop_cnt != 2'd0) begin
          drop_cnt <= drop_cnt - 2'd1;
        end else begin
          e_instr[fill_idx]  <= imem_rsp_data;
          e_filled[fill_idx] <= 1'b1;
        end
      end
      alloc_cnt <= alloc_cnt
                 + {1'b0, accept}
                 - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: queue-based fetch model, in-order
// latency memory, and directed scenarios with literal checks.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  int n_tests = 0;
  int n_fail  = 0;
  int lat     = 1;
  int cyc     = 0;

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk32(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chkb(input string nm, input logic act,
                      input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // memory: accepted reads captured mid-cycle, answered in order
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];
  bit          cap_acc  = 1'b0;
  logic [31:0] cap_addr = '0;

  always @(negedge clk) begin
    cap_acc  = imem_req_valid && imem_req_ready && !rst;
    cap_addr = imem_req_addr;
  end

  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (rst) begin
        mq.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end else begin
        if (cap_acc) mq.push_back('{cap_addr, cyc - 1 + lat});
        if (mq.size() > 0 && mq[0].due <= cyc) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = instr_of(mq[0].addr);
          void'(mq.pop_front());
        end else begin
          imem_rsp_valid = 1'b0;
          imem_rsp_data  = '0;
        end
      end
    end
  end

  // model: reads in flight (kept or flushed) and delivered pairs
  typedef struct {
    logic [31:0] pc;
    bit          keep;
  } fl_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;
  fl_t         inflight[$];
  ent_t        fifo[$];
  logic [31:0] m_pc = RST_PC;
  bit          e_valid;
  bit          e_pop;
  bit          e_req;
  int          occ;
  fl_t         f;

  // compare every cycle, then advance the model by that cycle
  always @(negedge clk) begin
    if (rst) begin
      chkb("rst_if_valid", if_valid, 1'b0);
      chkb("rst_req_valid", imem_req_valid, 1'b0);
      chk32("rst_if_pc", if_pc, 32'h0);
      chk32("rst_if_instr", if_instr, 32'h0);
      chk32("rst_req_addr", imem_req_addr, RST_PC);
      inflight.delete();
      fifo.delete();
      m_pc = RST_PC;
    end else begin
      e_valid = fifo.size() > 0;
      e_pop   = e_valid && if_ready;
      occ     = inflight.size() + fifo.size() - (e_pop ? 1 : 0);
      e_req   = !redirect_valid && occ < 2;
      chkb("if_valid", if_valid, e_valid);
      if (e_valid) begin
        chk32("if_pc", if_pc, fifo[0].pc);
        chk32("if_instr", if_instr, fifo[0].instr);
      end
      chkb("req_valid", imem_req_valid, e_req);
      chk32("req_addr", imem_req_addr, m_pc);
      if (e_pop) void'(fifo.pop_front());
      if (imem_rsp_valid && inflight.size() > 0) begin
        f = inflight.pop_front();
        if (f.keep && !redirect_valid)
          fifo.push_back('{f.pc, instr_of(f.pc)});
      end
      if (redirect_valid) begin
        fifo.delete();
        foreach (inflight[i]) inflight[i].keep = 1'b0;
        m_pc = redirect_pc;
      end else if (e_req && imem_req_ready) begin
        inflight.push_back('{m_pc, 1'b1});
        m_pc = m_pc + 32'd4;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (imem_req_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (if_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] pat_r = 16'b1101_1110_0111_1011;
  logic [15:0] pat_m = 16'b1011_0111_1101_1110;
  bit ok;
  int acc_cnt;

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b1;
    imem_req_ready = 1'b1;
    repeat (3) tick();

    // reset release: back-to-back fetch from RESET_PC
    rst = 1'b0;
    @(negedge clk);
    chkb("first_req_valid", imem_req_valid, 1'b1);
    chk32("first_req_addr", imem_req_addr, 32'h100);
    tick();
    @(negedge clk);
    chk32("second_req_addr", imem_req_addr, 32'h104);
    tick();
    @(negedge clk);
    chk32("third_req_addr", imem_req_addr, 32'h108);
    chkb("first_if_valid", if_valid, 1'b1);
    chk32("first_if_pc", if_pc, 32'h100);
    chk32("first_if_instr", if_instr, 32'h1257_6520);
    for (int k = 1; k <= 5; k++) begin
      tick();
      @(negedge clk);
      chkb("stream_valid", if_valid, 1'b1);
      chk32("stream_if_pc", if_pc, 32'h100 + 32'(4 * k));
    end

    // decode stall: credit runs out, no further requests
    tick();
    if_ready = 1'b0;
    acc_cnt  = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) acc_cnt++;
      tick();
    end
    @(negedge clk);
    chkb("stall_req_valid", imem_req_valid, 1'b0);
    chkb("stall_if_valid", if_valid, 1'b1);
    chkb("stall_accepts_le2", acc_cnt <= 2, 1'b1);
    tick();
    if_ready = 1'b1;
    @(negedge clk);
    chkb("resume_same_cycle", imem_req_valid, 1'b1);
    repeat (3) tick();

    // reset mid-stream, then imem back-pressure after release
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    @(negedge clk);
    chkb("midrst_if_valid", if_valid, 1'b0);
    chkb("midrst_req_valid", imem_req_valid, 1'b0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chkb("bp_req_valid", imem_req_valid, 1'b1);
      chk32("bp_req_addr", imem_req_addr, 32'h100);
      tick();
    end
    imem_req_ready = 1'b1;
    repeat (4) tick();

    // redirect with two 3-cycle reads outstanding
    imem_req_ready = 1'b0;
    repeat (6) tick();
    lat            = 3;
    imem_req_ready = 1'b1;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    @(negedge clk);
    chkb("redir_no_req", imem_req_valid, 1'b0);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chkb("drop_blocks_req", imem_req_valid, 1'b0);
    wait_req(10, ok);
    chkb("redir_req_seen", ok, 1'b1);
    chk32("redir_req_addr", imem_req_addr, 32'h200);
    wait_valid(20, ok);
    chkb("redir_valid_seen", ok, 1'b1);
    chk32("redir_if_pc", if_pc, 32'h200);
    chk32("redir_if_instr", if_instr, 32'h1157_6620);

    // redirect during pop + response, landing at the top of memory
    tick();
    lat = 1;
    repeat (12) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    @(negedge clk);
    chkb("redir_pop_valid", if_valid, 1'b1);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chkb("post_redir_empty", if_valid, 1'b0);
    chkb("post_redir_req", imem_req_valid, 1'b1);
    chk32("wrap_addr0", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    @(negedge clk);
    chk32("wrap_addr1", imem_req_addr, 32'h0000_0000);
    tick();
    @(negedge clk);
    chk32("wrap_if_pc", if_pc, 32'hFFFF_FFFC);

    // mixed back-pressure on both sides with 2-cycle memory
    lat = 2;
    for (int i = 0; i < 40; i++) begin
      tick();
      if_ready       = pat_r[i % 16];
      imem_req_ready = pat_m[i % 16];
      redirect_valid = (i == 20);
      redirect_pc    = 32'h300;
    end
    tick();
    if_ready       = 1'b1;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
